mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arb_prio.sv | 26 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: FSM state and owner encodings plus arbiter defaults.
// Imported by the arbiter top and its priority sub-module.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requesters.
// Data wins unless the fetch side has waited through STARVE_MAX data grants.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             sel_if,
    output logic             sel_d
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic starved;

    always_comb begin
        starved = if_req && (starve_cnt == CNT_MAX);
        sel_d   = d_req && !starved;
        sel_if  = if_req && !sel_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter, one outstanding access.
// state | meaning: IDLE = grant window, ISSUE = mem_en strobe, RESP = rvalid to owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                sel_if, sel_d;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (cnt_q),
        .sel_if     (sel_if),
        .sel_d      (sel_d)
    );

    // Captured address/data drive the memory port directly, so they hold between accesses.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        if_rdata   = if_rdata_q;
        d_rdata    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // Grants are suppressed while reset is asserted.
                if (rst) begin
                    if_gnt = sel_if;
                    d_gnt  = sel_d;
                    if (sel_d) begin
                        owner_d = OWN_D;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        state_d = ST_ISSUE;
                        if (if_req && (cnt_q != CNT_MAX)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sel_if) begin
                        owner_d = OWN_IF;
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_en  = 1'b1;
                mem_we  = we_q && (owner_q == OWN_D);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q == OWN_IF) begin
                    if_rvalid  = 1'b1;
                    if_rdata   = mem_rdata;
                    if_rdata_d = mem_rdata;
                end else begin
                    d_rvalid  = 1'b1;
                    d_rdata   = we_q ? '0 : mem_rdata;
                    d_rdata_d = we_q ? '0 : mem_rdata;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written conflict, starvation, reset and back-to-back sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] rdata;
        logic        exp_if;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;

        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0, 32'h00500093,
                    1'b1, 1'b0, 16'h0010, 32'h0, 32'h00500093};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 32'hDEADBEEF, 32'h12345678,
                    1'b0, 1'b1, 16'h0100, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 32'h11111111, 32'hCAFEF00D,
                    1'b0, 1'b0, 16'h0004, 32'h11111111, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 16'hFFFC, 1'b0, 1'b1, 16'h0300, 32'h55AA55AA, 32'hA5A5A5A5,
                    1'b1, 1'b0, 16'hFFFC, 32'h0, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 32'h00000001, 32'h87654321,
                    1'b0, 1'b1, 16'h0008, 32'h00000001, 32'h0};

        // Reset state
        repeat (2) cyc();
        #1;
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        cyc();
        rst = 1'b1;

        // Single-transaction table
        for (int i = 0; i < 5; i++) begin
            cyc();
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            #1;
            chk($sformatf("v%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, vecs[i].exp_if});
            chk($sformatf("v%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, !vecs[i].exp_if});
            chk($sformatf("v%0d_mem_en_n", i), {31'b0, mem_en}, 32'h0);
            cyc();
            if_req = 1'b0; d_req = 1'b0;
            #1;
            chk($sformatf("v%0d_mem_en", i), {31'b0, mem_en}, 32'h1);
            chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_mem_addr", i), {16'b0, mem_addr}, {16'b0, vecs[i].exp_addr});
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            chk($sformatf("v%0d_rvalid_early", i), {30'b0, if_rvalid, d_rvalid}, 32'h0);
            cyc();
            mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].exp_if});
            chk($sformatf("v%0d_d_rvalid", i), {31'b0, d_rvalid}, {31'b0, !vecs[i].exp_if});
            chk($sformatf("v%0d_rdata", i), vecs[i].exp_if ? if_rdata : d_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_mem_en_resp", i), {31'b0, mem_en}, 32'h0);
            cyc();
            mem_rdata = 32'h0BAD0BAD;
            #1;
            chk($sformatf("v%0d_idle_en_we", i), {30'b0, mem_en, mem_we}, 32'h0);
            chk($sformatf("v%0d_addr_hold", i), {16'b0, mem_addr}, {16'b0, vecs[i].exp_addr});
            chk($sformatf("v%0d_rvalid_late", i), {30'b0, if_rvalid, d_rvalid}, 32'h0);
            chk($sformatf("v%0d_rdata_hold", i), vecs[i].exp_if ? if_rdata : d_rdata, vecs[i].exp_rdata);
        end

        // Conflict: data first, fetch three cycles later
        cyc();
        if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
        #1;
        chk("cf_d_gnt", {31'b0, d_gnt}, 32'h1);
        chk("cf_if_gnt0", {31'b0, if_gnt}, 32'h0);
        cyc(); d_req = 1'b0; #1;
        chk("cf_d_addr", {16'b0, mem_addr}, 32'h0080);
        chk("cf_if_gnt1", {31'b0, if_gnt}, 32'h0);
        cyc(); mem_rdata = 32'h00000077; #1;
        chk("cf_d_rdata", d_rdata, 32'h00000077);
        chk("cf_if_gnt2", {31'b0, if_gnt}, 32'h0);
        cyc(); #1;
        chk("cf_if_gnt3", {31'b0, if_gnt}, 32'h1);
        cyc(); if_req = 1'b0; #1;
        chk("cf_if_addr", {16'b0, mem_addr}, 32'h0040);
        cyc(); mem_rdata = 32'h00000099; #1;
        chk("cf_if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("cf_if_rdata", if_rdata, 32'h00000099);
        chk("cf_d_rvalid", {31'b0, d_rvalid}, 32'h0);

        // Starvation: four data grants, then one fetch, repeating
        cyc();
        mem_rdata = 32'h13572468;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) cyc();
            if_req = 1'b1; if_addr = 16'h0044; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0088;
            #1;
            chk($sformatf("sv_if_gnt_c%0d", c), {31'b0, if_gnt}, {31'b0, (c == 12) || (c == 27)});
            chk($sformatf("sv_d_gnt_c%0d", c), {31'b0, d_gnt},
                {31'b0, (c % 3 == 0) && (c != 12) && (c != 27)});
        end
        cyc();
        if_req = 1'b0; d_req = 1'b0;
        #1;
        chk("sv_no_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);

        // Reset during ISSUE of a load
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        #1;
        chk("rs_d_gnt", {31'b0, d_gnt}, 32'h1);
        cyc(); d_req = 1'b0; rst = 1'b0; #1;
        chk("rs_issue_en", {31'b0, mem_en}, 32'h1);
        chk("rs_issue_addr", {16'b0, mem_addr}, 32'h0200);
        cyc(); rst = 1'b1; if_req = 1'b1; if_addr = 16'h0020; mem_rdata = 32'h0000FFFF; #1;
        chk("rs_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        chk("rs_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rs_mem_addr", {16'b0, mem_addr}, 32'h0);
        chk("rs_d_rdata", d_rdata, 32'h0);
        chk("rs_if_gnt", {31'b0, if_gnt}, 32'h1);
        cyc(); if_req = 1'b0; #1;
        chk("rs_if_issue", {15'b0, mem_en, mem_addr}, 32'h00010020);
        cyc(); mem_rdata = 32'h00A00513; #1;
        chk("rs_if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("rs_if_rdata", if_rdata, 32'h00A00513);

        // Back-to-back loads at alternating addresses
        cyc();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            d_req = 1'b1; d_we = 1'b0;
            d_addr = ((c / 3) % 2 == 0) ? 16'h0004 : 16'h0008;
            mem_rdata = (c % 3 == 2) ? (32'hD0000000 | 32'(c / 3)) : 32'hEEEEEEEE;
            #1;
            chk($sformatf("bb_d_gnt_c%0d", c), {31'b0, d_gnt}, {31'b0, c % 3 == 0});
            chk($sformatf("bb_if_rvalid_c%0d", c), {31'b0, if_rvalid}, 32'h0);
            chk($sformatf("bb_d_rvalid_c%0d", c), {31'b0, d_rvalid}, {31'b0, c % 3 == 2});
            if (c % 3 == 1)
                chk($sformatf("bb_addr_c%0d", c), {16'b0, mem_addr},
                    ((c / 3) % 2 == 0) ? 32'h0004 : 32'h0008);
            if (c % 3 == 2)
                chk($sformatf("bb_rdata_c%0d", c), d_rdata, 32'hD0000000 | 32'(c / 3));
        end
        cyc();
        d_req = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
